// File: rtl/out_mem_pixel_streamer.sv
// rtl/out_mem_pixel_streamer.sv - reads 128-bit output-memory words in pairs and streams them as 8-bit pixels
module out_mem_pixel_streamer #(
    parameter int          NUM_WORDS = 1024,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    output logic [15:0]  out_mem_rd_addr1,
    output logic [15:0]  out_mem_rd_addr2,
    input  logic [127:0] out_mem_rd_data1,
    input  logic [127:0] out_mem_rd_data2,
    output logic [7:0]   pix_data,
    output logic         pix_valid,
    input  logic         pix_ready,
    output logic         pix_last,
    output logic         busy,
    output logic         rd_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [16:0] NW = 17'(NUM_WORDS);

    state_t       state;
    state_t       state_nxt;
    logic [16:0]  word_ptr;     // index of the even word of the current pair, relative to BASE_ADDR
    logic [255:0] pair_buf;     // {odd word, even word}; even word's byte 0 goes out first
    logic [4:0]   byte_idx;
    logic         half_pair;    // final pair of an odd-length image: only the even word is sent
    logic         fire;
    logic         last_byte;
    logic         more_words;

    assign fire       = pix_valid & pix_ready;
    assign last_byte  = half_pair ? (byte_idx == 5'd15) : (byte_idx == 5'd31);
    assign more_words = (word_ptr + 17'd2) < NW;
    assign pix_data   = pair_buf[{byte_idx, 3'b000} +: 8];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and stream/status outputs, all decoded from the current state
    always_comb begin
        state_nxt = state;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        busy      = 1'b0;
        rd_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
                pix_last  = last_byte & ~more_words;
                if (fire && last_byte) begin
                    state_nxt = more_words ? S_LOAD : S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                rd_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address pair, word pointer, pair buffer and byte index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_mem_rd_addr1 <= 16'h0000;
            out_mem_rd_addr2 <= 16'h0000;
            word_ptr         <= 17'd0;
            pair_buf         <= 256'd0;
            byte_idx         <= 5'd0;
            half_pair        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        out_mem_rd_addr1 <= BASE_ADDR;
                        out_mem_rd_addr2 <= BASE_ADDR + 16'd1;
                        word_ptr         <= 17'd0;
                    end
                end
                S_LOAD: begin
                    // Memory data is combinational from the addresses set on the previous edge
                    if ((NW - word_ptr) == 17'd1) begin
                        pair_buf  <= {128'd0, out_mem_rd_data1};
                        half_pair <= 1'b1;
                    end else begin
                        pair_buf  <= {out_mem_rd_data2, out_mem_rd_data1};
                        half_pair <= 1'b0;
                    end
                    byte_idx <= 5'd0;
                end
                S_STREAM: begin
                    if (fire) begin
                        if (last_byte) begin
                            byte_idx <= 5'd0;
                            if (more_words) begin
                                word_ptr         <= word_ptr + 17'd2;
                                out_mem_rd_addr1 <= out_mem_rd_addr1 + 16'd2;
                                out_mem_rd_addr2 <= out_mem_rd_addr2 + 16'd2;
                            end
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/out_mem_pixel_streamer.md
Name: out_mem_pixel_streamer

Overview:
- Reader at the far end of the output memory: dm_top writes equalized 128-bit pixel words into output_mem; this block reads them back through the two memory read ports.
- It unpacks each word into 16 8-bit pixels and emits them on a valid/ready stream, in address order, to the downstream sink (display/compare/dump logic).
- Started by a one-cycle enable pulse after output_wt_done. Reports completion with a one-cycle rd_done pulse.

Parameters:
- NUM_WORDS, 1024, number of 128-bit words to read; legal range 1..65535 (the last address must not pass 0xFFFF).
- BASE_ADDR, 16'h0000, first output-memory word address.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (clears while 0).
- enable  input  1  start pulse; sampled only in IDLE.
- out_mem_rd_addr1  output  16  read address, port 1 (even word of the pair).
- out_mem_rd_addr2  output  16  read address, port 2 (odd word of the pair).
- out_mem_rd_data1  input  128  read data, port 1.
- out_mem_rd_data2  input  128  read data, port 2.
- pix_data  output  8  current pixel.
- pix_valid  output  1  pix_data is valid.
- pix_ready  input  1  sink accepts the pixel.
- pix_last  output  1  qualifies the final pixel of the image.
- busy  output  1  high from the start until DONE completes.
- rd_done  output  1  one-cycle completion pulse.

Behaviour:
- Memory timing: read data is combinational from the held address. The block samples out_mem_rd_data1/2 on the edge after the address registers change.
- Reset values: all outputs 0; out_mem_rd_addr1 = out_mem_rd_addr2 = 0; word pointer = 0; byte index = 0; state = IDLE.
- IDLE:
  - enable = 1 at edge N: addr1 = BASE_ADDR, addr2 = BASE_ADDR + 1, busy = 1, state -> LOAD.
  - enable = 0: stay in IDLE.
- LOAD (one cycle):
  - At edge N+1, capture data1 into buf0 and data2 into buf1.
  - pair_len = 32 bytes, or 16 if only one word remains (odd NUM_WORDS, final pair). When pair_len = 16, data2 is ignored.
  - byte index = 0, pix_valid = 1, state -> STREAM.
- STREAM:
  - pix_data = byte k of the 256-bit concatenation {buf1, buf0}, with byte k = bits [8k+7:8k] (buf0 byte 0 is sent first).
  - Each edge with pix_valid & pix_ready increments k. With pix_ready = 0, pix_data, pix_valid and pix_last hold stable.
  - When the handshake completes byte pair_len-1:
    - If words remain: addr1/addr2 advance by 2, pix_valid = 0, state -> LOAD. This is a one-cycle bubble per pair.
    - Otherwise: pix_valid = 0, state -> DONE.
- pix_last = 1 only while pix_valid = 1 and the presented byte is the final byte of the final word.
- DONE (one cycle): rd_done = 1, busy = 0 on exit, state -> IDLE. Address outputs keep their last values.
- enable while busy: ignored; no restart and no counter disturbance.
- Address arithmetic: 16-bit, modulo 2^16.
- Reset mid-operation: asynchronous clear to reset values regardless of state. A following enable restarts at BASE_ADDR.
- Throughput with pix_ready held 1: 16*NUM_WORDS pixels in 16*NUM_WORDS + ceil(NUM_WORDS/2) cycles, from the first LOAD to the edge entering DONE.

Test Plan:
- NUM_WORDS = 4, BASE_ADDR = 0, word0 = 128'h0F0E0D0C0B0A09080706050403020100, words 1–3 incrementing similarly, pix_ready = 1, enable pulse -> addr pairs 0/1 then 2/3.
  - First pixel 8'h00 one cycle after the LOAD state.
  - 64 pixels in order, with one bubble after pixel 32.
  - pix_last on pixel 64 only; a single rd_done pulse; busy falls afterwards.
- Same image, pix_ready toggling 1010… and also held 0 for 5 cycles mid-word -> no pixel dropped or duplicated; pix_data/pix_valid stable while stalled; 64 pixels total.
- NUM_WORDS = 3 -> 48 pixels; final LOAD addresses 2/3 with data2 ignored; pix_last on pixel 48.
- BASE_ADDR = 16'h0100, NUM_WORDS = 2 -> addr1 = 16'h0100, addr2 = 16'h0101; 32 pixels, then rd_done.
- enable pulsed again at pixel 10 of a run -> ignored; the stream completes normally with one rd_done.
- reset driven low at pixel 20 (between clock edges) -> all outputs 0 immediately. After release, an enable restarts at BASE_ADDR and the full correct sequence is reproduced.
